// File: rtl/enc_home_ctrl.sv
// Homing sequencer for one quadrature encoder axis: seeks the index pulse,
// captures the pre-home count, then holds the decoder clear while the axis settles.
module enc_home_ctrl #(
    parameter int COUNT_SIZE     = 11,
    parameter int TIMEOUT_W      = 32,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int SETTLE_CYCLES  = 1000
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  dir_cfg,
    input  logic                  enc_i,
    input  logic [COUNT_SIZE-1:0] count,
    output logic                  home,
    output logic                  seek_en,
    output logic                  seek_dir,
    output logic [COUNT_SIZE-1:0] offset,
    output logic                  busy,
    output logic                  done,
    output logic                  homed,
    output logic                  fault
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEEK   = 3'd1,
        ST_ZERO   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    state_t                  state, state_nxt;
    logic [TIMEOUT_W-1:0]    timer, timer_nxt;
    logic [SETTLE_W-1:0]     settle_cnt, settle_nxt;
    logic [COUNT_SIZE-1:0]   offset_nxt;
    logic                    seek_dir_nxt, homed_nxt, fault_nxt;
    logic                    seek_en_nxt, home_nxt, busy_nxt, done_nxt;

    logic idx_p0, idx_p1, idx_p2;
    logic idx_rise;

    // Index stage: p0/p1 synchronise the asynchronous pin, p2 holds history for edge detect
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            idx_p0 <= 1'b0;
            idx_p1 <= 1'b0;
            idx_p2 <= 1'b0;
        end else begin
            idx_p0 <= enc_i;
            idx_p1 <= idx_p0;
            idx_p2 <= idx_p1;
        end
    end

    assign idx_rise = idx_p1 & ~idx_p2;

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        settle_nxt   = settle_cnt;
        offset_nxt   = offset;
        seek_dir_nxt = seek_dir;
        homed_nxt    = homed;
        fault_nxt    = fault;

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt    = ST_SEEK;
                    seek_dir_nxt = dir_cfg;
                    timer_nxt    = '0;
                    homed_nxt    = 1'b0;
                    fault_nxt    = 1'b0;
                end
            end
            ST_SEEK: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (idx_rise) begin
                    offset_nxt = count;
                    state_nxt  = ST_ZERO;
                end else if (timer == TIMEOUT_LAST) begin
                    fault_nxt = 1'b1;
                    state_nxt = ST_FAULT;
                end else begin
                    timer_nxt = timer + TIMEOUT_W'(1);
                end
            end
            ST_ZERO: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    settle_nxt = '0;
                    state_nxt  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    homed_nxt = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    settle_nxt = settle_cnt + SETTLE_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                // Abort takes priority over a retry issued in the same cycle
                if (abort) begin
                    fault_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    state_nxt    = ST_SEEK;
                    seek_dir_nxt = dir_cfg;
                    timer_nxt    = '0;
                    homed_nxt    = 1'b0;
                    fault_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        seek_en_nxt = (state_nxt == ST_SEEK);
        home_nxt    = (state_nxt == ST_ZERO) || (state_nxt == ST_SETTLE);
        busy_nxt    = (state_nxt == ST_SEEK) || (state_nxt == ST_ZERO) ||
                      (state_nxt == ST_SETTLE);
        done_nxt    = (state_nxt == ST_DONE);
    end

    // Control stage: state, counters and outputs register together so outputs track state
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            timer      <= '0;
            settle_cnt <= '0;
            offset     <= '0;
            seek_dir   <= 1'b0;
            homed      <= 1'b0;
            fault      <= 1'b0;
            seek_en    <= 1'b0;
            home       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            settle_cnt <= settle_nxt;
            offset     <= offset_nxt;
            seek_dir   <= seek_dir_nxt;
            homed      <= homed_nxt;
            fault      <= fault_nxt;
            seek_en    <= seek_en_nxt;
            home       <= home_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_enc_home_ctrl.sv
// Bench for enc_home_ctrl: directed homing scenarios plus random traffic,
// checked every cycle against a phase-level model of the homing sequence.
module tb_enc_home_ctrl;

    localparam int CW  = 11;
    localparam int TW  = 32;
    localparam int TO  = 100;
    localparam int SC  = 4;

    localparam int M_IDLE   = 0;
    localparam int M_SEEK   = 1;
    localparam int M_ZERO   = 2;
    localparam int M_SETTLE = 3;
    localparam int M_DONE   = 4;
    localparam int M_FAULT  = 5;

    logic          sclk = 1'b0;
    logic          rst;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dir_cfg = 1'b0;
    logic          enc_i = 1'b0;
    logic [CW-1:0] count = '0;
    logic          home, seek_en, seek_dir, busy, done, homed, fault;
    logic [CW-1:0] offset;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    enc_home_ctrl #(
        .COUNT_SIZE(CW), .TIMEOUT_W(TW), .TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(SC)
    ) dut (
        .sclk(sclk), .rst(rst), .start(start), .abort(abort), .dir_cfg(dir_cfg),
        .enc_i(enc_i), .count(count), .home(home), .seek_en(seek_en),
        .seek_dir(seek_dir), .offset(offset), .busy(busy), .done(done),
        .homed(homed), .fault(fault)
    );

    always #5 sclk = ~sclk;

    // Model: phase of the homing sequence, cycles spent in seek/settle,
    // and the last three sampled pin values (index seen 3 edges after a rise).
    int            m_mode;
    int            m_seek_cyc;
    int            m_settle_cyc;
    logic [CW-1:0] m_offset;
    logic          m_dir, m_homed, m_fault;
    logic          e1, e2, e3;

    always @(posedge sclk or posedge rst) begin
        if (rst) begin
            m_mode <= M_IDLE; m_seek_cyc <= 0; m_settle_cyc <= 0;
            m_offset <= '0; m_dir <= 1'b0; m_homed <= 1'b0; m_fault <= 1'b0;
            e1 <= 1'b0; e2 <= 1'b0; e3 <= 1'b0;
        end else begin
            e1 <= enc_i; e2 <= e1; e3 <= e2;
            if ((m_mode == M_IDLE || m_mode == M_FAULT) && abort) begin
                m_mode  <= M_IDLE;
                m_fault <= 1'b0;
            end else if ((m_mode == M_IDLE || m_mode == M_FAULT) && start) begin
                m_mode <= M_SEEK; m_seek_cyc <= 1; m_dir <= dir_cfg;
                m_homed <= 1'b0; m_fault <= 1'b0;
            end else if (m_mode == M_SEEK || m_mode == M_ZERO || m_mode == M_SETTLE) begin
                if (abort) begin
                    m_mode <= M_IDLE;
                end else if (m_mode == M_SEEK) begin
                    if (e2 && !e3) begin
                        m_offset <= count;
                        m_mode   <= M_ZERO;
                    end else if (m_seek_cyc == TO) begin
                        m_mode  <= M_FAULT;
                        m_fault <= 1'b1;
                    end else begin
                        m_seek_cyc <= m_seek_cyc + 1;
                    end
                end else if (m_mode == M_ZERO) begin
                    m_mode <= M_SETTLE; m_settle_cyc <= 1;
                end else if (m_settle_cyc == SC) begin
                    m_mode  <= M_DONE;
                    m_homed <= 1'b1;
                end else begin
                    m_settle_cyc <= m_settle_cyc + 1;
                end
            end else if (m_mode == M_DONE) begin
                m_mode <= M_IDLE;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sclk) begin
        if (chk_on) begin
            if (rst) begin
                chk("rst_outputs", {home, seek_en, seek_dir, busy, done, homed, fault}, 0);
                chk("rst_offset", 32'(offset), 0);
            end else begin
                chk("seek_en", 32'(seek_en), 32'(m_mode == M_SEEK));
                chk("home", 32'(home), 32'(m_mode == M_ZERO || m_mode == M_SETTLE));
                chk("busy", 32'(busy),
                    32'(m_mode == M_SEEK || m_mode == M_ZERO || m_mode == M_SETTLE));
                chk("done", 32'(done), 32'(m_mode == M_DONE));
                chk("homed", 32'(homed), 32'(m_homed));
                chk("fault", 32'(fault), 32'(m_fault));
                chk("seek_dir", 32'(seek_dir), 32'(m_dir));
                chk("offset", 32'(offset), 32'(m_offset));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic d);
        start = 1'b1; dir_cfg = d;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    int home_cnt, done_cnt, seek_cnt;
    logic [CW-1:0] saved_off;

    initial begin
        rst = 1'b1;
        chk_on = 1'b1;
        tick(3);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_offset", 32'(offset), 0);
        @(negedge sclk);
        rst = 1'b0;
        tick(2);

        // Normal home
        count = 11'd37;
        pulse_start(1'b1);
        chk("t1_seek_en", 32'(seek_en), 1);
        chk("t1_seek_dir", 32'(seek_dir), 1);
        tick(9);
        enc_i = 1'b1;
        home_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            home_cnt += int'(home);
            done_cnt += int'(done);
        end
        chk("t1_home_cycles", 32'(home_cnt), SC + 1);
        chk("t1_done_pulses", 32'(done_cnt), 1);
        chk("t1_offset", 32'(offset), 37);
        chk("t1_homed", 32'(homed), 1);
        chk("t1_busy_after", 32'(busy), 0);

        // Timeout
        enc_i = 1'b0;
        tick(5);
        pulse_start(1'b0);
        seek_cnt = 0;
        for (int i = 0; i < 300 && seek_en; i++) begin
            seek_cnt++;
            tick();
        end
        chk("t2_seek_cycles", 32'(seek_cnt), TO);
        chk("t2_fault", 32'(fault), 1);
        chk("t2_seek_en", 32'(seek_en), 0);
        chk("t2_homed", 32'(homed), 0);
        pulse_start(1'b1);
        chk("t2_retry_fault", 32'(fault), 0);
        chk("t2_retry_seek", 32'(seek_en), 1);
        pulse_abort();
        chk("t2_abort_idle", 32'(busy), 0);

        // Abort on the second SETTLE cycle
        pulse_start(1'b0);
        tick(3);
        enc_i = 1'b1;
        tick(5);
        chk("t3_home_before", 32'(home), 1);
        pulse_abort();
        chk("t3_home_after", 32'(home), 0);
        chk("t3_busy_after", 32'(busy), 0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            done_cnt += int'(done);
        end
        chk("t3_no_done", 32'(done_cnt), 0);
        chk("t3_homed", 32'(homed), 0);

        // Index rise lands on the last timeout cycle
        enc_i = 1'b0;
        count = 11'h5A5;
        tick(5);
        pulse_start(1'b1);
        tick(97);
        enc_i = 1'b1;
        tick(3);
        chk("t4_zero_home", 32'(home), 1);
        chk("t4_fault", 32'(fault), 0);
        chk("t4_offset", 32'(offset), 32'h5A5);
        tick(10);

        // start and abort together from IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t5_stay_idle", 32'(busy), 0);
        chk("t5_no_seek", 32'(seek_en), 0);

        // Index pulses while IDLE
        saved_off = offset;
        enc_i = 1'b0; tick(3); enc_i = 1'b1; tick(3); enc_i = 1'b0; tick(4);
        chk("t6_idle_offset", 32'(offset), 32'(saved_off));
        chk("t6_idle_busy", 32'(busy), 0);

        // Index pulse during SETTLE
        count = 11'd100;
        pulse_start(1'b0);
        tick(2);
        enc_i = 1'b1;
        tick(4);
        count = 11'd200;
        enc_i = 1'b0; tick(); enc_i = 1'b1;
        tick(10);
        chk("t6_settle_offset", 32'(offset), 100);
        chk("t6_settle_homed", 32'(homed), 1);

        // start while in SEEK does not restart the timeout
        enc_i = 1'b0;
        tick(4);
        pulse_start(1'b1);
        seek_cnt = 0;
        for (int i = 0; i < 300 && seek_en; i++) begin
            seek_cnt++;
            start = (seek_cnt == 20);
            tick();
            start = 1'b0;
        end
        chk("t7_seek_cycles", 32'(seek_cnt), TO);
        pulse_abort();
        chk("t7_fault_cleared", 32'(fault), 0);

        // Async reset mid-SEEK
        pulse_start(1'b1);
        tick(5);
        #2;
        rst = 1'b1;
        #1;
        chk("t8_async_seek_en", 32'(seek_en), 0);
        chk("t8_async_busy", 32'(busy), 0);
        chk("t8_async_home", 32'(home), 0);
        chk("t8_async_offset", 32'(offset), 0);
        chk("t8_async_dir", 32'(seek_dir), 0);
        tick(2);
        @(negedge sclk);
        rst = 1'b0;
        tick();
        count = 11'd321;
        pulse_start(1'b0);
        tick(10);
        enc_i = 1'b1;
        tick(20);
        chk("t8_rehome_homed", 32'(homed), 1);
        chk("t8_rehome_offset", 32'(offset), 321);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom_range(0, 19) == 0);
            abort   = ($urandom_range(0, 59) == 0);
            dir_cfg = 1'($urandom);
            count   = CW'($urandom);
            if ($urandom_range(0, 14) == 0) enc_i = ~enc_i;
            tick();
        end
        start = 1'b0; abort = 1'b0;
        tick(2);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
